// File: rtl/cond_wait_sequencer.sv
// Purpose : steps through a programmable list of conditions over signed registers a/b/c,
//           pulsing cont per step, waiting for the condition, then idling GAP cycles.
// Latency : cont (ARM) -> step_done no earlier than 1 cycle; register write visible next cycle.
// Backpr. : none; a step that stays false for TIMEOUT WAIT cycles ends the run in TOUT.
// Ports   : clk/rst (async, active-high); start; cfg_we/cfg_idx/cfg_code program the table
//           while idle; wr_en/wr_sel/wr_data write a/b/c (sel 3 = no write); a_q/b_q/c_q
//           register values; cont/step_done pulses; busy/done/timeout_err levels; step_idx.
module cond_wait_sequencer #(
  parameter int WIDTH   = 32,
  parameter int NSTEPS  = 3,
  parameter int GAP     = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_idx,
  input  logic [2:0]       cfg_code,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] c_q,
  output logic             cont,
  output logic             busy,
  output logic [2:0]       step_idx,
  output logic             step_done,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_WAIT, ST_GAP, ST_DONE, ST_TOUT} state_t;

  // Counters only need to reach TIMEOUT-1 / GAP-1 before the state moves on.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [2:0]    STEP_LAST = 3'(NSTEPS - 1);

  state_t          state, state_d;
  logic [CW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      codes [0:7];
  logic [2:0]      cur_code;
  logic            cond_ok;
  logic            last_step;
  logic            idle_like;

  // Sign-extend to WIDTH+1 so a+b can never wrap.
  logic signed [WIDTH:0] ax, bx, cx, sum;
  assign ax  = $signed({a_q[WIDTH-1], a_q});
  assign bx  = $signed({b_q[WIDTH-1], b_q});
  assign cx  = $signed({c_q[WIDTH-1], c_q});
  assign sum = ax + bx;

  assign cur_code  = codes[step_idx];
  assign last_step = (step_idx == STEP_LAST);
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_TOUT);

  always_comb begin
    cond_ok = 1'b0;
    case (cur_code)
      3'd0:    cond_ok = (ax > bx);
      3'd1:    cond_ok = (sum < cx);
      3'd2:    cond_ok = (ax < bx) && (bx > cx);
      3'd3:    cond_ok = (ax == bx);
      3'd4:    cond_ok = (c_q != '0);
      3'd5:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Shared registers: written in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0:    a_q <= wr_data;
        2'd1:    b_q <= wr_data;
        2'd2:    c_q <= wr_data;
        default: ;
      endcase
    end
  end

  // Condition table; writes beyond the program length are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) codes[i] <= 3'd5;
      codes[0] <= 3'd0;
      codes[1] <= 3'd1;
      codes[2] <= 3'd2;
    end else if (cfg_we && !busy && ({1'b0, cfg_idx} < 4'(NSTEPS))) begin
      codes[cfg_idx] <= cfg_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cont      = 1'b0;
    step_done = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        cont    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cond_ok) begin
          step_done = 1'b1;
          if (GAP == 0) state_d = last_step ? ST_DONE : ST_ARM;
          else          state_d = ST_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = ST_TOUT;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = last_step ? ST_DONE : ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_idx <= 3'd0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      // Re-arming from WAIT/GAP means the next step; from idle it means a fresh run.
      if (idle_like && start)    step_idx <= 3'd0;
      else if (state_d == ST_ARM) step_idx <= step_idx + 3'd1;

      if (state == ST_ARM)       wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + CW'(1);

      if (state == ST_GAP) gap_cnt <= gap_cnt + GW'(1);
      else                 gap_cnt <= '0;
    end
  end

  assign busy        = (state == ST_ARM) || (state == ST_WAIT) || (state == ST_GAP);
  assign done        = (state == ST_DONE);
  assign timeout_err = (state == ST_TOUT);

endmodule

// File: tb/tb_cond_wait_sequencer.sv
module tb_cond_wait_sequencer;
  localparam int W  = 32;
  localparam int NS = 3;
  localparam int GP = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_idx = 3'd0;
  logic [2:0]   cfg_code = 3'd0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_sel = 2'd0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] a_q, b_q, c_q;
  logic         cont, busy, step_done, done, timeout_err;
  logic [2:0]   step_idx;

  cond_wait_sequencer #(.WIDTH(W), .NSTEPS(NS), .GAP(GP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_code(cfg_code), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .a_q(a_q), .b_q(b_q), .c_q(c_q), .cont(cont), .busy(busy),
    .step_idx(step_idx), .step_done(step_done), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int sd_cnt = 0;
  int cont_q[$];
  logic [W-1:0] ea = '0, eb = '0, ec = '0;

  // Pulse log: at the posedge the outputs still reflect the cycle just ending.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (cont) cont_q.push_back(cyc_n);
    if (step_done) sd_cnt <= sd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return cont;
      1:       return step_done;
      2:       return done;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_for(input int which, input int maxc, input string tag);
    int n = 0;
    while (!pick(which) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(pick(which)), 64'd1);
  endtask

  task automatic wr(input logic [1:0] s, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = s; wr_data = d;
    if (s == 2'd0) ea = d;
    if (s == 2'd1) eb = d;
    if (s == 2'd2) ec = d;
    @(negedge clk);
    wr_en = 1'b0; wr_sel = 2'd0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [2:0] code);
    cfg_we = 1'b1; cfg_idx = idx; cfg_code = code;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // code, a, b, c, expected pass on the first WAIT cycle
  logic [2:0]   v_code [10] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd3, 3'd4, 3'd4, 3'd2, 3'd2, 3'd7};
  logic [W-1:0] v_a    [10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFB, 32'd1, 32'd9,
                                32'd0, 32'd0, 32'd1, 32'd1, 32'd3};
  logic [W-1:0] v_b    [10] = '{32'd1, 32'h7FFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd9,
                                32'd0, 32'd0, 32'd3, 32'd3, 32'd4};
  logic [W-1:0] v_c    [10] = '{32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd0, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd5};
  logic         v_p    [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n0, sd0, t0, c0;

    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_a", 64'(a_q), 0);
    chk("rst_b", 64'(b_q), 0);
    chk("rst_c", 64'(c_q), 0);
    chk("rst_flags", {59'd0, cont, busy, step_done, done, timeout_err}, 0);
    chk("rst_idx", 64'(step_idx), 0);
    rst = 1'b0;
    @(negedge clk);

    // Default program: a>b, a+b<c, a<b&&b>c
    n0 = cont_q.size(); sd0 = sd_cnt;
    go();
    chk("d_cont0", 64'(cont), 1);
    chk("d_busy", 64'(busy), 1);
    chk("d_idx0", 64'(step_idx), 0);
    wr(2'd1, 32'd1);
    chk("d_s0_b1", 64'(step_done), 0);
    wr(2'd0, 32'd2);
    chk("d_s0_a2", 64'(step_done), 1);
    wait_for(0, 20, "d_cont1");
    chk("d_idx1", 64'(step_idx), 1);
    wr(2'd2, 32'd3);
    chk("d_s1_c3", 64'(step_done), 0);
    wr(2'd2, 32'd4);
    chk("d_s1_c4", 64'(step_done), 1);
    wait_for(0, 20, "d_cont2");
    chk("d_idx2", 64'(step_idx), 2);
    wr(2'd1, 32'd5);
    chk("d_s2_b5", 64'(step_done), 1);
    wait_for(2, 20, "d_done");
    chk("d_idx_end", 64'(step_idx), 2);
    chk("d_busy_end", 64'(busy), 0);
    chk("d_ncont", 64'(cont_q.size() - n0), 3);
    chk("d_nsd", 64'(sd_cnt - sd0), 3);
    for (int i = n0 + 1; i < cont_q.size(); i++)
      chk("d_spacing", 64'((cont_q[i] - cont_q[i-1]) >= GP), 1);

    // Immediate satisfy
    cfg(3'd0, 3'd5); cfg(3'd1, 3'd5); cfg(3'd2, 3'd5);
    go();
    chk("i_cont0", 64'(cont), 1);
    c0 = cyc_n;
    for (int i = 0; i < NS; i++) begin
      if (i > 0) wait_for(0, 20, "i_cont");
      @(negedge clk);
      chk("i_sd", 64'(step_done), 1);
    end
    wait_for(2, 30, "i_done");
    chk("i_lat", 64'(cyc_n - c0), 64'(NS * (2 + GP)));

    // Timeout at step 0
    cfg(3'd0, 3'd6);
    sd0 = sd_cnt;
    go();
    chk("t_cont", 64'(cont), 1);
    t0 = cyc_n;
    wait_for(3, 30, "t_err");
    chk("t_lat", 64'(cyc_n - t0), 64'(TO + 1));
    chk("t_idx", 64'(step_idx), 0);
    chk("t_done", 64'(done), 0);
    chk("t_nsd", 64'(sd_cnt - sd0), 0);
    go();
    chk("t_clr", 64'(timeout_err), 0);
    chk("t_recont", 64'(cont), 1);
    wait_for(3, 30, "t_err2");

    // Signed compare / overflow vectors on step 0
    for (int v = 0; v < 10; v++) begin
      cfg(3'd0, v_code[v]);
      wr(2'd0, v_a[v]);
      wr(2'd1, v_b[v]);
      wr(2'd2, v_c[v]);
      go();
      @(negedge clk);
      chk($sformatf("v%0d_sd", v), 64'(step_done), 64'(v_p[v]));
      if (v_p[v]) wait_for(2, 40, $sformatf("v%0d_done", v));
      else        wait_for(3, 40, $sformatf("v%0d_tout", v));
    end

    // Busy protection
    cfg(3'd0, 3'd6);
    sd0 = sd_cnt;
    go();
    @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_code = 3'd5;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    chk("b_nocont", 64'(cont), 0);
    chk("b_idx", 64'(step_idx), 0);
    chk("b_busy", 64'(busy), 1);
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 32'h1234;
    @(negedge clk);
    wr_en = 1'b0; wr_sel = 2'd0;
    chk("b_sel3_a", 64'(a_q), 64'(ea));
    chk("b_sel3_b", 64'(b_q), 64'(eb));
    chk("b_sel3_c", 64'(c_q), 64'(ec));
    wait_for(3, 30, "b_tout");
    chk("b_nsd", 64'(sd_cnt - sd0), 0);

    // Reset while waiting on step 1
    cfg(3'd0, 3'd5); cfg(3'd1, 3'd6);
    go();
    chk("r_cont0", 64'(cont), 1);
    @(negedge clk);
    wait_for(0, 20, "r_cont1");
    @(negedge clk);
    chk("r_idx1", 64'(step_idx), 1);
    #2 rst = 1'b1;
    #1;
    chk("r_a", 64'(a_q), 0);
    chk("r_b", 64'(b_q), 0);
    chk("r_c", 64'(c_q), 0);
    chk("r_flags", {59'd0, cont, busy, step_done, done, timeout_err}, 0);
    chk("r_idx", 64'(step_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = cont_q.size();
    repeat (10) @(negedge clk);
    chk("r_quiet", 64'(cont_q.size() - n0), 0);
    chk("r_idle", 64'(busy), 0);
    go();
    chk("r_restart", 64'(cont), 1);
    wait_for(3, 30, "r_tout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cond_wait_sequencer.md
Name: cond_wait_sequencer

Overview:
- Hardware sequencer for multi-variable level-sensitive waits over three shared signed registers a, b and c.
- Steps through a programmable list of conditions. For each step it:
  - pulses a `cont` event to the producer side;
  - holds until the condition over the current register values is true;
  - waits a fixed gap, then advances.
- Sits between a producer that writes a/b/c and a consumer that needs ordered condition completion, with a timeout guard per step.

Parameters:
- WIDTH, 32, data width of a, b, c and wr_data; values are two's-complement signed.
- NSTEPS, 3, number of condition steps in the program (1..8).
- GAP, 10, idle cycles after a step is satisfied and before the next `cont` pulse (0 allowed).
- TIMEOUT, 1023, maximum WAIT cycles per step before error (>=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin program at step 0; honoured only in IDLE, DONE or TOUT.
- cfg_we  input  1  write one condition code; honoured only when not busy.
- cfg_idx  input  3  step index for cfg_we; values >= NSTEPS are ignored.
- cfg_code  input  3  condition code for that step.
- wr_en  input  1  register write strobe.
- wr_sel  input  2  write target: 0=a, 1=b, 2=c, 3=no write.
- wr_data  input  WIDTH  write value.
- a_q, b_q, c_q  output  WIDTH each  current register values.
- cont  output  1  one-cycle pulse at the start of each step.
- busy  output  1  high in ARM, WAIT and GAP.
- step_idx  output  3  current step number.
- step_done  output  1  one-cycle pulse when the current condition is seen true.
- done  output  1  level, all steps complete; cleared by start or rst.
- timeout_err  output  1  level, a step exceeded TIMEOUT; cleared by start or rst.

Behaviour:
- Reset values:
  - a_q, b_q, c_q = 0.
  - cont, busy, step_done, done, timeout_err = 0.
  - step_idx = 0; state = IDLE.
  - Condition table resets to {0, 1, 2, 5, 5, 5, 5, 5}.
- Reset asserted mid-operation aborts immediately to the reset values above; no pulses are emitted.
- Condition codes (signed compare; the sum is computed at WIDTH+1 bits, so it never overflows):
  - 0: a>b
  - 1: a+b<c
  - 2: a<b && b>c
  - 3: a==b
  - 4: c!=0
  - 5: true
  - 6, 7: never true (timeout only)
- Register writes:
  - Take effect at the clk edge, in any state, including IDLE.
  - A write in cycle N is visible to condition evaluation in cycle N+1.
- FSM states: IDLE, ARM, WAIT, GAP, DONE, TOUT.
  - IDLE/DONE/TOUT + start: go to ARM. Clear done and timeout_err. Set step_idx=0.
  - ARM: cont=1 for exactly this cycle; clear the wait counter; next state WAIT.
  - WAIT: evaluate the condition for step_idx every cycle.
    - If true: step_done=1 for this cycle. Go to GAP (or straight to the next-step decision if GAP=0).
    - Else if the wait counter equals TIMEOUT-1: go to TOUT and set timeout_err=1.
    - Else: increment the wait counter.
  - A condition already true on WAIT entry passes in that first WAIT cycle (latency ARM to step_done = 1 cycle).
  - GAP: count GAP cycles, then decide the next step:
    - if step_idx==NSTEPS-1: go to DONE and set done=1;
    - else: increment step_idx and go to ARM.
  - DONE/TOUT: hold step_idx; wait for start.
- start while busy is ignored. cfg_we while busy is ignored. start and cfg_we in the same idle cycle: the config write applies first, and the run uses the new code.
- Value changes that make a condition true and then false again between evaluations are not captured. Evaluation is sampled per cycle.

Test Plan:
- Default program:
  - start; after 1st cont write b=1, then a=2;
  - after 2nd cont write c=3, then c=4;
  - after 3rd cont write b=5.
  - Expected:
    - step_done after a=2 is visible;
    - step 1 stays waiting at c=3 (3 is not < 3) and completes at c=4;
    - step 2 completes at b=5;
    - done=1, step_idx=2, exactly 3 cont pulses, spaced at least GAP apart.
- Immediate satisfy: program all codes=5.
  - Expected: each step_done exactly 1 cycle after its cont; done after 3*(2+GAP) cycles.
- Timeout: code 6 at step 0, TIMEOUT=8.
  - Expected: timeout_err=1 exactly 8 WAIT cycles after ARM; no step_done; step_idx=0.
  - Then start: timeout_err clears and cont pulses again.
- Signed/overflow:
  - a=0x7FFFFFFF, b=1, c=0x80000000, code 1: must not pass.
  - a=-5, b=-7 with code 0: passes.
- Reset mid-WAIT:
  - assert rst at step 1.
  - Expected: all outputs 0 and registers 0 in the same cycle; no cont after release until start.
- Busy protection:
  - start and cfg_we during WAIT are ignored; program and step_idx are unchanged.
  - A write to wr_sel=3 changes no register.
